// File: rtl/ir_pkg.sv
// Shared IR definitions: state encoding and carrier half-period derivation,
// used by both the transmit and receive sides.
package ir_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_BURST = S_BURST,
      ST_GAP   = S_GAP
   } state_t;

   // Clock cycles per carrier half-period, truncated toward zero.
   function automatic int half_of(input int clk_hz, input int carrier_hz);
      return clk_hz / (2 * carrier_hz);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase counter: runs 0..2*HALF-1, reports the carrier level and
// one-cycle ticks at the last high phase (fall) and the last phase (wrap).
module ir_carrier_gen #(
   parameter int HALF = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic level,
   output logic fall,
   output logic wrap
);

   localparam int PH_W = $clog2(2 * HALF);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF - 1);
   localparam logic [PH_W-1:0] PH_FALL = PH_W'(HALF - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF);

   logic [PH_W-1:0] phase;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst || clear)
         phase <= '0;
      else if (phase == PH_LAST)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   assign level = (phase < PH_HALF);
   assign fall  = (phase == PH_FALL);
   assign wrap  = (phase == PH_LAST);

endmodule

// File: rtl/ir_burst_tx.sv
// IR emitter driver: one start pulse sends BURST carrier periods followed by
// GAP silent periods, then pulses done.
module ir_burst_tx
   import ir_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int CARRIER_HZ = 38_000,
   parameter int BURST      = 10,
   parameter int GAP        = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic start,
   output logic pin,
   output logic busy,
   output logic done
);

   localparam int HALF = half_of(CLK_HZ, CARRIER_HZ);
   localparam int PW   = $clog2(max_int(BURST, GAP) + 1);
   localparam logic [PW-1:0] BURST_LAST = PW'(BURST - 1);
   localparam logic [PW-1:0] GAP_LAST   = PW'((GAP > 0) ? GAP - 1 : 0);

   if (HALF < 1) begin : g_bad_half
      $error("ir_burst_tx: CLK_HZ/(2*CARRIER_HZ) must be at least 1");
   end
   if (BURST < 1) begin : g_bad_burst
      $error("ir_burst_tx: BURST must be at least 1");
   end
   if (GAP < 0) begin : g_bad_gap
      $error("ir_burst_tx: GAP must not be negative");
   end

   state_t          state, state_d;
   logic [PW-1:0]   period, period_d;
   logic            pin_d, busy_d, done_d;
   logic            level, fall, wrap, clear;

   // Phase restarts at zero whenever the frame is not running or is launched.
   assign clear = (state == ST_IDLE) || (state_d == ST_IDLE);

   ir_carrier_gen #(.HALF(HALF)) u_carrier (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .level (level),
      .fall  (fall),
      .wrap  (wrap)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d  = state;
      period_d = period;
      pin_d    = 1'b0;
      done_d   = 1'b0;
      if (!enable) begin
         state_d  = ST_IDLE;
         period_d = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               period_d = '0;
               if (start) begin
                  state_d = ST_BURST;
                  pin_d   = 1'b1;
               end
            end
            ST_BURST: begin
               if (wrap) begin
                  if (period == BURST_LAST) begin
                     period_d = '0;
                     if (GAP == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_GAP;
                     end
                  end else begin
                     period_d = period + 1'b1;
                     pin_d    = 1'b1;
                  end
               end else begin
                  // Pin tracks the level of the phase that follows this edge.
                  pin_d = level & ~fall;
               end
            end
            ST_GAP: begin
               if (wrap) begin
                  if (period == GAP_LAST) begin
                     state_d  = ST_IDLE;
                     period_d = '0;
                     done_d   = 1'b1;
                  end else begin
                     period_d = period + 1'b1;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               period_d = '0;
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         period <= '0;
         pin    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         period <= period_d;
         pin    <= pin_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule

// File: tb/tb_ir_burst_tx.sv
// Bench for ir_burst_tx: three builds (small frame, GAP=0, defaults) checked
// every cycle against a frame-offset model plus literal timing expectations.
module tb_ir_burst_tx;

   logic       clk;
   logic [2:0] rst_v, en_v, start_v;
   wire  [2:0] pin_v, busy_v, done_v;

   // Per build: carrier half-period, burst periods, gap periods.
   int hp[3] = '{4, 4, 157};
   int bp[3] = '{3, 3, 10};
   int gp[3] = '{2, 0, 10};

   bit m_active[3];
   bit m_done[3];
   int m_k[3];
   bit cmp_on;

   int n_checks;
   int n_pass;

   ir_burst_tx #(.CLK_HZ(16), .CARRIER_HZ(2), .BURST(3), .GAP(2)) u_main (
      .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .start(start_v[0]),
      .pin(pin_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   ir_burst_tx #(.CLK_HZ(16), .CARRIER_HZ(2), .BURST(3), .GAP(0)) u_gap0 (
      .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .start(start_v[1]),
      .pin(pin_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   ir_burst_tx u_dflt (
      .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .start(start_v[2]),
      .pin(pin_v[2]), .busy(busy_v[2]), .done(done_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: a frame is "cycle k since acceptance"; outputs follow from k.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_v[i] || !en_v[i]) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
         end else if (m_active[i]) begin
            m_k[i]++;
            m_done[i] = (m_k[i] == (bp[i] + gp[i]) * 2 * hp[i]);
            if (m_done[i]) m_active[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (start_v[i]) begin
               m_active[i] = 1'b1;
               m_k[i]      = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < 3; i++) begin
            int  per;
            bit  ep;
            per = 2 * hp[i];
            ep  = m_active[i] && (m_k[i] < bp[i] * per) && ((m_k[i] % per) < hp[i]);
            check($sformatf("pin[%0d]", i),  32'(pin_v[i]),  32'(ep));
            check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_active[i]));
            check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
         end
      end
   end

   // Caller raises start_v[i] at a negedge; this follows the frame to done,
   // optionally re-pulsing start at frame cycles p1/p2.
   task automatic run_frame(input int i, input int p1, input int p2, input int exp_done,
                            input logic [7:0] exp_pat, input int exp_low, input string tag);
      int         n;
      int         low;
      logic [7:0] pat;
      bit         seen;
      n    = 0;
      low  = -1;
      pat  = '0;
      seen = 1'b0;
      while (n <= exp_done + 20) begin
         @(negedge clk);
         if (n < 8) pat[3'(7 - n)] = pin_v[i];
         if (low < 0 && pin_v[i] === 1'b0) low = n;
         if (done_v[i] === 1'b1) begin
            seen = 1'b1;
            break;
         end
         start_v[i] = (n == p1) || (n == p2);
         n++;
      end
      start_v[i] = 1'b0;
      check({tag, "_done_cycle"}, seen ? n : -1, exp_done);
      check({tag, "_pin_pattern"}, 32'(pat), 32'(exp_pat));
      check({tag, "_first_low"}, low, exp_low);
   endtask

   initial begin
      int dones;
      n_checks = 0;
      n_pass   = 0;
      cmp_on   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_active[i] = 1'b0;
         m_done[i]   = 1'b0;
         m_k[i]      = 0;
      end
      rst_v   = 3'b111;
      en_v    = 3'b111;
      start_v = 3'b111;

      // Reset held three edges with start high.
      @(posedge clk);
      #1 cmp_on = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy_held", 32'(busy_v), 32'd0);
      rst_v   = 3'b000;
      start_v = 3'b000;
      repeat (3) @(negedge clk);
      check("rst_pin_after", 32'(pin_v), 32'd0);
      check("rst_busy_after", 32'(busy_v), 32'd0);

      // Nominal frame.
      start_v[0] = 1'b1;
      run_frame(0, -1, -1, 40, 8'hF0, 4, "nominal");

      // Back-to-back launch one cycle after done, with starts while busy.
      start_v[0] = 1'b1;
      run_frame(0, 5, 30, 40, 8'hF0, 4, "busy_start");

      // Start landing on the done edge is dropped.
      repeat (2) @(negedge clk);
      start_v[0] = 1'b1;
      run_frame(0, 39, -1, 40, 8'hF0, 4, "start_at_done");
      repeat (3) @(negedge clk);
      check("start_at_done_idle", 32'(busy_v[0]), 32'd0);

      // Enable abort mid-burst.
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_pre_pin", 32'(pin_v[0]), 32'd1);
      en_v[0] = 1'b0;
      @(negedge clk);
      check("abort_pin", 32'(pin_v[0]), 32'd0);
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      dones = 0;
      repeat (50) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) dones++;
      end
      check("abort_no_done", dones, 0);
      en_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b1;
      run_frame(0, -1, -1, 40, 8'hF0, 4, "reenable");

      // GAP=0 build.
      start_v[1] = 1'b1;
      run_frame(1, -1, -1, 24, 8'hF0, 4, "gap0");
      @(negedge clk);
      check("gap0_idle_after", 32'(busy_v[1]), 32'd0);

      // Default build: HALF=157, 20 periods to done.
      start_v[2] = 1'b1;
      run_frame(2, -1, -1, 6280, 8'hFF, 157, "defaults");

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

endmodule
